piece_scheduler: RTL and testbench

PIECE_SCHEDULER -- requirements
Module: piece_scheduler

---
 rtl/piece_scheduler_if.sv | 28 ++
 rtl/piece_scheduler.sv | 133 +++++++++++++
 tb/tb_piece_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/piece_scheduler_if.sv
// Handshake bundle between the piece scheduler, its hw_rng and the piece requester.
// slave = scheduler side, master = requester/RNG side.
interface piece_scheduler_if;
  logic        seed_req;
  logic [31:0] seed_in;
  logic        rng_load;
  logic [31:0] rng_seed;
  logic [31:0] random_state;
  logic        piece_pop;
  logic        piece_valid;
  logic [2:0]  piece_out;
  logic        next_valid;
  logic [2:0]  next_piece;
  logic [15:0] pieces_issued;
  logic        busy;

  modport master (
    output seed_req, seed_in, random_state, piece_pop,
    input  rng_load, rng_seed, piece_valid, piece_out, next_valid, next_piece,
           pieces_issued, busy
  );

  modport slave (
    input  seed_req, seed_in, random_state, piece_pop,
    output rng_load, rng_seed, piece_valid, piece_out, next_valid, next_piece,
           pieces_issued, busy
  );
endinterface

// File: rtl/piece_scheduler.sv
// Piece queue fed from an external RNG: seeds the RNG, keeps QUEUE_DEPTH pieces buffered.
// Optional macro PIECE_REROLL_EN: invalid or repeated draws are re-rolled from random_state[5:3].
module piece_scheduler #(
  parameter int          QUEUE_DEPTH  = 4,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_001F
) (
  input logic              clk,
  input logic              reset,
  piece_scheduler_if.slave bus
);
  localparam int            CW   = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

`ifdef PIECE_REROLL_EN
  typedef enum logic [1:0] {SEED, FILL, REROLL, READY} state_e;
`else
  typedef enum logic [1:0] {SEED, FILL, READY} state_e;
`endif

  state_e                        state_q, state_d;
  logic [31:0]                   seed_q, seed_d;
  logic [CW-1:0]                 cnt_q, cnt_d, cnt_pop;
  logic [2:0]                    last_q, last_d;
  logic [15:0]                   issued_q, issued_d;
  logic [QUEUE_DEPTH-1:0][2:0]   queue_q, queue_d;

  logic [2:0] d_smp, push_val;
  logic       pop_ok, push_en, reroll_hit;

  assign d_smp = bus.random_state[2:0];

`ifdef PIECE_REROLL_EN
  logic [2:0] e_smp;
  logic       unused_rs;
  assign e_smp      = bus.random_state[5:3];
  assign reroll_hit = (state_q == FILL) && ((d_smp == 3'd7) || (d_smp == last_q));
  assign unused_rs  = ^bus.random_state[31:6];
`else
  logic unused_rs;
  assign reroll_hit = 1'b0;
  assign unused_rs  = ^{bus.random_state[31:3], last_q};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SEED;
      seed_q   <= SEED_DEFAULT;
      cnt_q    <= '0;
      last_q   <= 3'd7;
      issued_q <= '0;
      queue_q  <= '0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      issued_q <= issued_d;
      queue_q  <= queue_d;
    end
  end

  // Queue datapath: pop shifts the head out, push lands just past the post-pop tail.
  always_comb begin
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    issued_d = issued_q;
    queue_d  = queue_q;
    pop_ok   = 1'b0;
    push_en  = 1'b0;
    push_val = d_smp;
    cnt_pop  = cnt_q;
    if (bus.seed_req) begin
      seed_d = bus.seed_in;
      cnt_d  = '0;
      last_d = 3'd7;
    end else begin
      pop_ok = bus.piece_pop && (cnt_q != '0);
      case (state_q)
        FILL: push_en = (d_smp != 3'd7) && !reroll_hit;
`ifdef PIECE_REROLL_EN
        REROLL: begin
          push_en  = 1'b1;
          push_val = (e_smp >= 3'd7) ? (e_smp - 3'd7) : e_smp;
        end
`endif
        default: push_en = 1'b0;
      endcase
      if ((cnt_q == FULL) && !pop_ok) push_en = 1'b0;
      cnt_pop = cnt_q - CW'(pop_ok);
      if (pop_ok) begin
        issued_d = issued_q + 16'd1;
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) queue_d[i] = queue_q[i+1];
        queue_d[QUEUE_DEPTH-1] = '0;
      end
      if (push_en) begin
        for (int i = 0; i < QUEUE_DEPTH; i++)
          if (CW'(i) == cnt_pop) queue_d[i] = push_val;
        last_d = push_val;
      end
      cnt_d = cnt_pop + CW'(push_en);
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.seed_req) begin
      state_d = SEED;
    end else begin
      case (state_q)
        SEED: state_d = FILL;
        default: begin
          state_d = (cnt_d == FULL) ? READY : FILL;
`ifdef PIECE_REROLL_EN
          if (reroll_hit) state_d = REROLL;
`endif
        end
      endcase
    end
  end

  // The load strobe is held off while reset is asserted even though the state is SEED.
  always_comb begin
    bus.rng_load      = (state_q == SEED) && reset;
    bus.rng_seed      = seed_q;
    bus.piece_valid   = (cnt_q != '0);
    bus.next_valid    = (cnt_q >= CW'(2));
    bus.piece_out     = (cnt_q != '0) ? queue_q[0] : 3'd0;
    bus.next_piece    = (cnt_q >= CW'(2)) ? queue_q[1] : 3'd0;
    bus.pieces_issued = issued_q;
    bus.busy          = (state_q != READY);
  end
endmodule

// File: tb/tb_piece_scheduler.sv
// Bench for piece_scheduler: queue-level reference model feeds a scoreboard of expected
// pieces; a negedge monitor pops it on every accepted pop and checks all outputs.
`timescale 1ns/1ps
module tb_piece_scheduler;
  localparam int          DEPTH = 4;
  localparam logic [31:0] SEED0 = 32'h0000_001F;
`ifdef PIECE_REROLL_EN
  localparam bit REROLL = 1'b1;
`else
  localparam bit REROLL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  piece_scheduler_if bus();

  piece_scheduler #(.QUEUE_DEPTH(DEPTH), .SEED_DEFAULT(SEED0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: abstract queue of upcoming pieces plus a few flags.
  logic [2:0]  exp_q[$];
  int          m_cnt = 0;
  bit          m_seeding = 1'b1;
  bit          m_reroll = 1'b0;
  bit          started = 1'b0;
  bit          wrapped = 1'b0;
  logic [2:0]  m_last = 3'd7;
  logic [2:0]  m_d, m_e;
  logic [15:0] m_issued = '0;
  logic [31:0] m_seed = SEED0;

  task automatic m_push(input logic [2:0] v);
    exp_q.push_back(v);
    m_cnt++;
    m_last = v;
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!reset) begin
        m_cnt = 0; m_seeding = 1'b1; m_reroll = 1'b0; m_last = 3'd7;
        m_issued = '0; m_seed = SEED0; exp_q.delete();
      end else if (bus.seed_req) begin
        m_seed = bus.seed_in; m_cnt = 0; m_seeding = 1'b1; m_reroll = 1'b0;
        m_last = 3'd7; exp_q.delete();
      end else if (m_seeding) begin
        m_seeding = 1'b0;
      end else begin
        bit room;
        room = (m_cnt < DEPTH);
        m_d  = bus.random_state[2:0];
        m_e  = bus.random_state[5:3];
        if (bus.piece_pop && m_cnt > 0) begin
          m_cnt--;
          m_issued = m_issued + 16'd1;
          if (m_issued == 16'd0) wrapped = 1'b1;
        end
        if (m_reroll) begin
          m_push((m_e == 3'd7) ? 3'd0 : m_e);
          m_reroll = 1'b0;
        end else if (room) begin
          if (m_d == 3'd7 || (REROLL && m_d == m_last)) m_reroll = REROLL;
          else m_push(m_d);
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (started) begin
        chk("piece_valid", {31'd0, bus.piece_valid}, {31'd0, exp_q.size() >= 1});
        chk("next_valid",  {31'd0, bus.next_valid},  {31'd0, exp_q.size() >= 2});
        chk("piece_out",   {29'd0, bus.piece_out},   (exp_q.size() >= 1) ? {29'd0, exp_q[0]} : 32'd0);
        chk("next_piece",  {29'd0, bus.next_piece},  (exp_q.size() >= 2) ? {29'd0, exp_q[1]} : 32'd0);
        chk("busy",        {31'd0, bus.busy},        {31'd0, m_cnt != DEPTH});
        chk("rng_load",    {31'd0, bus.rng_load},    {31'd0, m_seeding && reset});
        chk("rng_seed",    bus.rng_seed,             m_seed);
        chk("pieces_issued", {16'd0, bus.pieces_issued}, {16'd0, m_issued});
        if (reset && bus.piece_pop && !bus.seed_req && exp_q.size() > 0)
          void'(exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1_200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic [31:0] rs, input bit pop, input bit sreq, input logic [31:0] sin);
    bus.random_state = rs;
    bus.piece_pop    = pop;
    bus.seed_req     = sreq;
    bus.seed_in      = sin;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [31:0] r;
    reset = 1'b0;
    bus.seed_req = 1'b0; bus.seed_in = '0; bus.random_state = '0; bus.piece_pop = 1'b0;
    repeat (5) cyc(0, 1'b0, 1'b0, 0);
    chk("reset_rng_load", {31'd0, bus.rng_load}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd1);

    // Release: one load strobe with the default seed, then fill 3,1,4,2.
    reset = 1'b1;
    #1;
    chk("first_rng_load", {31'd0, bus.rng_load}, 32'd1);
    chk("first_rng_seed", bus.rng_seed, 32'h0000_001F);
    cyc(0, 1'b0, 1'b0, 0);
    chk("load_one_cycle", {31'd0, bus.rng_load}, 32'd0);
    cyc(3, 1'b0, 1'b0, 0); cyc(1, 1'b0, 1'b0, 0); cyc(4, 1'b0, 1'b0, 0); cyc(2, 1'b0, 1'b0, 0);
    chk("fill_head", {29'd0, bus.piece_out}, 32'd3);
    chk("fill_next", {29'd0, bus.next_piece}, 32'd1);
    chk("fill_busy", {31'd0, bus.busy}, 32'd0);

    cyc(5, 1'b1, 1'b0, 0);
    chk("pop_head", {29'd0, bus.piece_out}, 32'd1);
    chk("pop_next", {29'd0, bus.next_piece}, 32'd4);
    chk("pop_issued", {16'd0, bus.pieces_issued}, 32'd1);
    cyc(6, 1'b0, 1'b0, 0);
    chk("refill_busy", {31'd0, bus.busy}, 32'd0);

    // Discarded draws of 7, then a 2 lands at the tail.
    cyc(0, 1'b1, 1'b0, 0);
    cyc(7, 1'b0, 1'b0, 0); cyc(7, 1'b0, 1'b0, 0); cyc(7, 1'b0, 1'b0, 0);
`ifndef PIECE_REROLL_EN
    chk("seven_no_push", {31'd0, bus.busy}, 32'd1);
`endif
    cyc(2, 1'b0, 1'b0, 0);
`ifndef PIECE_REROLL_EN
    chk("seven_then_two_busy", {31'd0, bus.busy}, 32'd0);
    chk("seven_then_two_head", {29'd0, bus.piece_out}, 32'd4);
`endif

    // Reseed with a simultaneous pop: pop is dropped.
    cyc(0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("reseed_load", {31'd0, bus.rng_load}, 32'd1);
    chk("reseed_seed", bus.rng_seed, 32'hDEAD_BEEF);
    chk("reseed_valid", {31'd0, bus.piece_valid}, 32'd0);
    chk("reseed_issued", {16'd0, bus.pieces_issued}, 32'd2);

    // Repeat of last_pushed=5, with random_state[5:3]=7 for the reroll draw.
    cyc(0, 1'b0, 1'b0, 0);
    cyc(5, 1'b0, 1'b0, 0); cyc(5, 1'b0, 1'b0, 0); cyc(32'h3B, 1'b0, 1'b0, 0);
    chk("repeat_entry1", {29'd0, bus.next_piece}, REROLL ? 32'd0 : 32'd5);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      cyc($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0), $urandom);
    end
    reset = 1'b1;

    // Counter wrap: continuous pops with draws never equal to 7.
    reset = 1'b0;
    cyc(0, 1'b0, 1'b0, 0);
    reset = 1'b1;
    wrapped = 1'b0;
    for (int i = 0; i < 85000 && !wrapped; i++) begin
      r = $urandom;
      r[2:0] = 3'($urandom_range(0, 6));
      cyc(r, 1'b1, 1'b0, 0);
    end
    chk("wrap_reached", {31'd0, wrapped}, 32'd1);
    chk("wrap_issued", {16'd0, bus.pieces_issued}, 32'd0);

    // Pops against an empty queue are ignored.
    cyc(7, 1'b0, 1'b1, 32'h0000_1234);
    cyc(7, 1'b1, 1'b0, 0); cyc(7, 1'b1, 1'b0, 0); cyc(7, 1'b1, 1'b0, 0);
    chk("empty_pop_issued", {16'd0, bus.pieces_issued}, 32'd0);
`ifndef PIECE_REROLL_EN
    chk("empty_pop_valid", {31'd0, bus.piece_valid}, 32'd0);
`endif
    cyc(0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
